// File: rtl/piso_frame_serializer.sv
// Parallel-in serial-out frame serializer: accepts words over valid/ready,
// buffers one word, and shifts it out one bit per clock with frame strobes.
module piso_frame_serializer #(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame_start,
    output logic             frame_last,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFTING
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sreg, sreg_nxt;
    logic [WIDTH-1:0] hbuf, hbuf_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             hvalid, hvalid_nxt;

    logic             at_last;
    logic             accept;
    logic             load;
    logic [WIDTH-1:0] sreg_shifted;

    assign at_last = (cnt == LAST);
    // din_ready is !hvalid, so accept and load can never fire on the same edge.
    assign accept  = din_valid && !hvalid;
    assign load    = hvalid && ((state == IDLE) || at_last);

    assign sreg_shifted = LSB_FIRST ? {1'b0, sreg[WIDTH-1:1]}
                                    : {sreg[WIDTH-2:0], 1'b0};

    // NOTE: every next-state signal gets its hold value first, so no path
    // through this block leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nxt  = state;
        sreg_nxt   = sreg;
        hbuf_nxt   = hbuf;
        cnt_nxt    = cnt;
        hvalid_nxt = hvalid;

        if (accept) begin
            hbuf_nxt   = din;
            hvalid_nxt = 1'b1;
        end

        case (state)
            IDLE: begin
                if (load) begin
                    sreg_nxt   = hbuf;
                    cnt_nxt    = '0;
                    hvalid_nxt = 1'b0;
                    state_nxt  = SHIFTING;
                end
            end
            SHIFTING: begin
                if (!at_last) begin
                    cnt_nxt  = cnt + CW'(1);
                    sreg_nxt = sreg_shifted;
                end else if (load) begin
                    sreg_nxt   = hbuf;
                    cnt_nxt    = '0;
                    hvalid_nxt = 1'b0;
                end else begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            sreg   <= '0;
            hbuf   <= '0;
            cnt    <= '0;
            hvalid <= 1'b0;
        end else begin
            state  <= state_nxt;
            sreg   <= sreg_nxt;
            hbuf   <= hbuf_nxt;
            cnt    <= cnt_nxt;
            hvalid <= hvalid_nxt;
        end
    end

    assign sout_valid  = (state == SHIFTING);
    assign sout        = sout_valid & (LSB_FIRST ? sreg[0] : sreg[WIDTH-1]);
    assign frame_start = sout_valid & (cnt == '0);
    assign frame_last  = sout_valid & at_last;
    assign din_ready   = !hvalid;
    assign busy        = sout_valid | hvalid;

endmodule

// File: tb/tb_piso_frame_serializer.sv
// Directed bench for piso_frame_serializer: MSB-first and LSB-first instances
// share stimulus; a per-cycle record queue and a SIPO model hold observations.
module tb_piso_frame_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] din;
    logic       din_valid;

    logic m_ready, m_sout, m_valid, m_start, m_last, m_busy;
    logic l_ready, l_sout, l_valid, l_start, l_last, l_busy;

    int n_checks = 0;
    int n_fail   = 0;

    piso_frame_serializer #(.WIDTH(4), .LSB_FIRST(1'b0)) dut_msb (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(m_ready), .sout(m_sout), .sout_valid(m_valid),
        .frame_start(m_start), .frame_last(m_last), .busy(m_busy)
    );

    piso_frame_serializer #(.WIDTH(4), .LSB_FIRST(1'b1)) dut_lsb (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(l_ready), .sout(l_sout), .sout_valid(l_valid),
        .frame_start(l_start), .frame_last(l_last), .busy(l_busy)
    );

    always #5 clk = ~clk;

    // Downstream 4-bit SIPO fed by the MSB-first instance, shifting every clock.
    logic [3:0] sipo = 4'h0;
    always @(posedge clk) sipo <= {sipo[2:0], m_sout};

    typedef struct {
        logic       v, s, st, la, rd, bz;
        logic       lv, ls, lst, lla;
        logic [3:0] q;
    } rec_t;

    rec_t recs[$];
    logic mon_en = 1'b0;

    // One record per cycle, taken 2 time units after each rising edge.
    always @(posedge clk) begin
        #2;
        if (mon_en)
            recs.push_back('{v: m_valid, s: m_sout, st: m_start, la: m_last,
                             rd: m_ready, bz: m_busy, lv: l_valid, ls: l_sout,
                             lst: l_start, lla: l_last, q: sipo});
    end

    // Presents w from the current falling edge until an edge accepts it;
    // din carries junk while din_ready is low.
    task automatic send(input logic [3:0] w);
        bit ok = 1'b0;
        din_valid = 1'b1;
        for (int t = 0; t < 20; t++) begin
            if (din_ready_now()) begin
                din = w;
                ok  = 1'b1;
                break;
            end
            din = ~w;
            @(negedge clk);
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL send_timeout: word %h not accepted, din_ready=%b expected 1", w, m_ready);
        end
        @(negedge clk);
    endtask

    function automatic logic din_ready_now();
        return m_ready;
    endfunction

    task automatic wait_recs(input int n, input string name);
        for (int t = 0; t < 100 && recs.size() < n; t++) @(negedge clk);
        n_checks++;
        if (recs.size() < n) begin
            n_fail++;
            $display("FAIL %s_timeout: got %0d records expected %0d", name, recs.size(), n);
        end
    endtask

    task automatic test_reset();
        #7;
        n_checks++;
        if ({m_sout, m_valid, m_start, m_last, m_ready, m_busy} !== 6'b000010) begin
            n_fail++;
            $display("FAIL reset_msb: got %b expected 000010",
                     {m_sout, m_valid, m_start, m_last, m_ready, m_busy});
        end
        n_checks++;
        if ({l_sout, l_valid, l_start, l_last, l_ready, l_busy} !== 6'b000010) begin
            n_fail++;
            $display("FAIL reset_lsb: got %b expected 000010",
                     {l_sout, l_valid, l_start, l_last, l_ready, l_busy});
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if ({m_sout, m_valid, m_ready, m_busy} !== 4'b0010) begin
            n_fail++;
            $display("FAIL reset_release: got %b expected 0010", {m_sout, m_valid, m_ready, m_busy});
        end
    endtask

    task automatic test_single_word();
        logic [3:0] w = 4'b1011;
        @(negedge clk);
        recs.delete();
        mon_en = 1'b1;
        send(w);
        din_valid = 1'b0;
        wait_recs(7, "single");
        mon_en = 1'b0;
        n_checks++;
        if (recs[0].v !== 1'b0 || recs[0].rd !== 1'b0 || recs[0].bz !== 1'b1) begin
            n_fail++;
            $display("FAIL single_after_accept: v/rd/bz got %b%b%b expected 001",
                     recs[0].v, recs[0].rd, recs[0].bz);
        end
        for (int i = 1; i <= 4; i++) begin
            n_checks++;
            if ({recs[i].v, recs[i].s, recs[i].st, recs[i].la} !== {1'b1, w[4-i], i == 1, i == 4}) begin
                n_fail++;
                $display("FAIL single_bit%0d: v/s/start/last got %b%b%b%b expected %b%b%b%b", i,
                         recs[i].v, recs[i].s, recs[i].st, recs[i].la, 1'b1, w[4-i], i == 1, i == 4);
            end
        end
        n_checks++;
        if (recs[5].v !== 1'b0 || recs[5].bz !== 1'b0 || recs[5].s !== 1'b0) begin
            n_fail++;
            $display("FAIL single_end: v/bz/s got %b%b%b expected 000", recs[5].v, recs[5].bz, recs[5].s);
        end
        n_checks++;
        if (recs[5].q !== w) begin
            n_fail++;
            $display("FAIL single_sipo: got %b expected %b", recs[5].q, w);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] e = 8'b1010_0101;
        @(negedge clk);
        recs.delete();
        mon_en = 1'b1;
        send(4'hA);
        send(4'h5);
        din_valid = 1'b0;
        wait_recs(10, "b2b");
        mon_en = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            n_checks++;
            if ({recs[i].v, recs[i].s, recs[i].st, recs[i].la} !==
                {1'b1, e[8-i], (i % 4) == 1, (i % 4) == 0}) begin
                n_fail++;
                $display("FAIL b2b_bit%0d: v/s/start/last got %b%b%b%b expected %b%b%b%b", i,
                         recs[i].v, recs[i].s, recs[i].st, recs[i].la,
                         1'b1, e[8-i], (i % 4) == 1, (i % 4) == 0);
            end
        end
        n_checks++;
        if (recs[9].v !== 1'b0 || recs[0].v !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_edges: v before/after got %b%b expected 00", recs[0].v, recs[9].v);
        end
    endtask

    task automatic test_backpressure();
        logic [11:0] e = {4'h3, 4'hE, 4'h8};
        @(negedge clk);
        recs.delete();
        mon_en = 1'b1;
        send(4'h3);
        send(4'hE);
        send(4'h8);
        din_valid = 1'b0;
        wait_recs(14, "bp");
        mon_en = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            n_checks++;
            if ({recs[i].v, recs[i].s, recs[i].st, recs[i].la} !==
                {1'b1, e[12-i], (i % 4) == 1, (i % 4) == 0}) begin
                n_fail++;
                $display("FAIL bp_bit%0d: v/s/start/last got %b%b%b%b expected %b%b%b%b", i,
                         recs[i].v, recs[i].s, recs[i].st, recs[i].la,
                         1'b1, e[12-i], (i % 4) == 1, (i % 4) == 0);
            end
        end
        for (int i = 0; i <= 13; i++) begin
            logic rd_exp = (i == 1) || (i == 5) || (i >= 9);
            n_checks++;
            if (recs[i].rd !== rd_exp || recs[i].bz !== (i != 13)) begin
                n_fail++;
                $display("FAIL bp_ready%0d: rd/bz got %b%b expected %b%b", i,
                         recs[i].rd, recs[i].bz, rd_exp, i != 13);
            end
        end
    endtask

    task automatic test_reset_mid_word();
        logic [3:0] w = 4'h9;
        @(negedge clk);
        recs.delete();
        mon_en = 1'b1;
        send(4'hC);
        send(4'h3);
        n_checks++;
        if (recs[2].v !== 1'b1 || recs[2].s !== 1'b1 || recs[2].rd !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_before: v/s/rd got %b%b%b expected 110", recs[2].v, recs[2].s, recs[2].rd);
        end
        #2;
        rst       = 1'b1;
        din_valid = 1'b0;
        #1;
        n_checks++;
        if ({m_sout, m_valid, m_start, m_last, m_ready, m_busy} !== 6'b000010) begin
            n_fail++;
            $display("FAIL midrst_async: got %b expected 000010",
                     {m_sout, m_valid, m_start, m_last, m_ready, m_busy});
        end
        @(negedge clk);
        rst = 1'b0;
        send(w);
        din_valid = 1'b0;
        wait_recs(10, "midrst");
        mon_en = 1'b0;
        n_checks++;
        if (recs[3].v !== 1'b0 || recs[4].v !== 1'b0 || recs[4].rd !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_flush: v3/v4/rd4 got %b%b%b expected 000", recs[3].v, recs[4].v, recs[4].rd);
        end
        for (int i = 5; i <= 8; i++) begin
            n_checks++;
            if ({recs[i].v, recs[i].s} !== {1'b1, w[8-i]}) begin
                n_fail++;
                $display("FAIL midrst_bit%0d: v/s got %b%b expected 1%b", i - 4, recs[i].v, recs[i].s, w[8-i]);
            end
        end
        n_checks++;
        if (recs[9].v !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_end: v got %b expected 0", recs[9].v);
        end
    endtask

    task automatic test_lsb_first();
        logic [3:0] lexp = 4'b1000;
        @(negedge clk);
        recs.delete();
        mon_en = 1'b1;
        send(4'b0001);
        din_valid = 1'b0;
        wait_recs(6, "lsb");
        mon_en = 1'b0;
        for (int i = 0; i <= 5; i++) begin
            logic vexp = (i >= 1) && (i <= 4);
            logic sexp = vexp && lexp[4-i];
            n_checks++;
            if ({recs[i].lv, recs[i].ls, recs[i].lst, recs[i].lla} !== {vexp, sexp, i == 1, i == 4}) begin
                n_fail++;
                $display("FAIL lsb_cycle%0d: v/s/start/last got %b%b%b%b expected %b%b%b%b", i,
                         recs[i].lv, recs[i].ls, recs[i].lst, recs[i].lla, vexp, sexp, i == 1, i == 4);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        din       = 4'h0;
        din_valid = 1'b0;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_word();
        test_lsb_first();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
